// File: rtl/fb_scanout.sv
// fb_scanout: framebuffer scanout stage behind the VGA timing generator.
// It turns hcount/vcount into reads of a double-buffered, integer-downscaled
// framebuffer and drives RGB out. Sync and blank are delayed so they stay
// aligned with the returned pixel data.
// It also owns the front-buffer select and the frame-synchronous swap handshake
// with the renderer.
//
// Pipeline (t = cycle in which the counts are presented):
//   t+1 : rd_addr_out / rd_en_out registered
//   t+3 : rd_data_in valid (READ_LATENCY = 2 after rd_addr_out)
//   t+4 : RGB and delayed hsync/vsync/blank visible   (LAT = READ_LATENCY + 2)
// READ_LATENCY must be at least 1 so that the active-flag delay line has
// at least two stages.
// PIXEL_W is expected to be 12, packed as {r[3:0], g[3:0], b[3:0]}.

module fb_scanout #(
   parameter int H_ACTIVE     = 1024,
   parameter int V_ACTIVE     = 768,
   parameter int SCALE_LOG2   = 2,
   parameter int FB_ADDR_W    = 16,
   parameter int PIXEL_W      = 12,
   parameter int READ_LATENCY = 2
) (
   input  logic                 pixel_clk_in,
   input  logic                 rst,
   input  logic [10:0]          hcount_in,
   input  logic [9:0]           vcount_in,
   input  logic                 hsync_in,
   input  logic                 vsync_in,
   input  logic                 blank_in,
   input  logic                 swap_req_in,
   output logic                 swap_ack_out,
   output logic                 fb_sel_out,
   output logic                 frame_start_out,
   output logic [FB_ADDR_W:0]   rd_addr_out,
   output logic                 rd_en_out,
   input  logic [PIXEL_W-1:0]   rd_data_in,
   output logic [3:0]           red_out,
   output logic [3:0]           green_out,
   output logic [3:0]           blue_out,
   output logic                 hsync_out,
   output logic                 vsync_out,
   output logic                 blank_out
);

   // Total input-to-output latency and framebuffer geometry.
   localparam int LAT  = READ_LATENCY + 2;
   localparam int FB_W = H_ACTIVE >> SCALE_LOG2;

   localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
   localparam logic [9:0]  V_LIM = 10'(V_ACTIVE);

   // Combinational decode of the incoming position.
   logic                 active_s;
   logic                 moved_s;
   logic                 frame_pos_s;
   logic                 vblank_pos_s;
   logic                 swap_evt_s;
   logic                 pix_on_s;
   logic [FB_ADDR_W-1:0] fb_addr_s;

   // Position-change tracking.
   logic [10:0]          prev_h_r;
   logic [9:0]           prev_v_r;
   logic                 first_r;

   // Buffer select, handshake and frame marker.
   logic                 fb_sel_r;
   logic                 swap_ack_r;
   logic                 frame_start_r;

   // Address stage.
   logic [FB_ADDR_W:0]   rd_addr_r;
   logic                 rd_en_r;

   // Alignment delay lines; index 0 is the youngest stage.
   logic [LAT-1:0]       hs_pipe_r;
   logic [LAT-1:0]       vs_pipe_r;
   logic [LAT-1:0]       bl_pipe_r;
   logic [LAT-2:0]       act_pipe_r;

   // Output colour registers.
   logic [3:0]           red_r;
   logic [3:0]           green_r;
   logic [3:0]           blue_r;

   // Decode the active window, the position-change flag and the event positions.
   always_comb begin
      active_s     = (hcount_in < H_LIM) && (vcount_in < V_LIM);
      moved_s      = first_r || (hcount_in != prev_h_r) || (vcount_in != prev_v_r);
      frame_pos_s  = (hcount_in == 11'd0) && (vcount_in == 10'd0);
      vblank_pos_s = (hcount_in == 11'd0) && (vcount_in == V_LIM);
      swap_evt_s   = moved_s && vblank_pos_s && swap_req_in;
      // The row index times the framebuffer width, plus the column. Anything
      // beyond the half-buffer address width is dropped on purpose.
      fb_addr_s    = FB_ADDR_W'(((32'(vcount_in) >> SCALE_LOG2) * 32'(FB_W))
                                + (32'(hcount_in) >> SCALE_LOG2));
      // At this point the oldest active/blank stages line up with rd_data_in.
      pix_on_s     = act_pipe_r[LAT-2] && !bl_pipe_r[LAT-2];
   end

   // Remember the last position seen, so that a paused timing generator never re-fires events.
   always_ff @(posedge pixel_clk_in) begin
      if (rst) begin
         first_r  <= 1'b1;
         prev_h_r <= 11'd0;
         prev_v_r <= 10'd0;
      end else begin
         first_r  <= 1'b0;
         prev_h_r <= hcount_in;
         prev_v_r <= vcount_in;
      end
   end

   // Frame-start pulse, plus the buffer swap taken only on entry to vertical blank.
   always_ff @(posedge pixel_clk_in) begin
      if (rst) begin
         fb_sel_r      <= 1'b0;
         swap_ack_r    <= 1'b0;
         frame_start_r <= 1'b0;
      end else begin
         frame_start_r <= moved_s && frame_pos_s;
         swap_ack_r    <= swap_evt_s;
         if (swap_evt_s) begin
            fb_sel_r <= ~fb_sel_r;
         end else begin
            fb_sel_r <= fb_sel_r;
         end
      end
   end

   // Register the BRAM read address. It holds outside the active window so the read port stays quiet.
   always_ff @(posedge pixel_clk_in) begin
      if (rst) begin
         rd_addr_r <= {(FB_ADDR_W + 1){1'b0}};
         rd_en_r   <= 1'b0;
      end else begin
         rd_en_r <= active_s;
         if (active_s) begin
            rd_addr_r <= {fb_sel_r, fb_addr_s};
         end else begin
            rd_addr_r <= rd_addr_r;
         end
      end
   end

   // Delay sync, blank and active so they line up with the pixel data returned by the BRAM.
   always_ff @(posedge pixel_clk_in) begin
      if (rst) begin
         hs_pipe_r  <= {LAT{1'b0}};
         vs_pipe_r  <= {LAT{1'b0}};
         bl_pipe_r  <= {LAT{1'b1}};
         act_pipe_r <= {(LAT - 1){1'b0}};
      end else begin
         hs_pipe_r  <= {hs_pipe_r[LAT-2:0], hsync_in};
         vs_pipe_r  <= {vs_pipe_r[LAT-2:0], vsync_in};
         bl_pipe_r  <= {bl_pipe_r[LAT-2:0], blank_in};
         act_pipe_r <= {act_pipe_r[LAT-3:0], active_s};
      end
   end

   // Capture the returned pixel, forcing black outside the active window and during blank.
   always_ff @(posedge pixel_clk_in) begin
      if (rst) begin
         red_r   <= 4'd0;
         green_r <= 4'd0;
         blue_r  <= 4'd0;
      end else if (pix_on_s) begin
         red_r   <= rd_data_in[PIXEL_W-1 -: 4];
         green_r <= rd_data_in[PIXEL_W-5 -: 4];
         blue_r  <= rd_data_in[PIXEL_W-9 -: 4];
      end else begin
         red_r   <= 4'd0;
         green_r <= 4'd0;
         blue_r  <= 4'd0;
      end
   end

   assign swap_ack_out    = swap_ack_r;
   assign fb_sel_out      = fb_sel_r;
   assign frame_start_out = frame_start_r;
   assign rd_addr_out     = rd_addr_r;
   assign rd_en_out       = rd_en_r;
   assign red_out         = red_r;
   assign green_out       = green_r;
   assign blue_out        = blue_r;
   assign hsync_out       = hs_pipe_r[LAT-1];
   assign vsync_out       = vs_pipe_r[LAT-1];
   assign blank_out       = bl_pipe_r[LAT-1];

endmodule

// File: tb/tb_fb_scanout.sv
// Testbench for fb_scanout. The stimulus is a sequence of timing-generator
// positions. A BRAM model returns a fixed function of the address after two
// cycles. Expected outputs come from a per-cycle history of the inputs:
// each output is looked up directly from the inputs LAT (or 1) cycles earlier.
module tb_fb_scanout;

   localparam int H_ACTIVE = 1024;
   localparam int V_ACTIVE = 768;
   localparam int FB_W     = 256;
   localparam int H_TOTAL  = 1344;
   localparam int V_TOTAL  = 806;
   localparam int MAXC     = 8192;

   logic        pixel_clk_in = 1'b0;
   logic        rst = 1'b1;
   logic [10:0] hcount_in = 11'd0;
   logic [9:0]  vcount_in = 10'd0;
   logic        hsync_in = 1'b1;
   logic        vsync_in = 1'b1;
   logic        blank_in = 1'b1;
   logic        swap_req_in = 1'b0;
   logic        swap_ack_out, fb_sel_out, frame_start_out, rd_en_out;
   logic [16:0] rd_addr_out;
   logic [11:0] rd_data_in;
   logic [3:0]  red_out, green_out, blue_out;
   logic        hsync_out, vsync_out, blank_out;

   fb_scanout dut (
      .pixel_clk_in(pixel_clk_in), .rst(rst),
      .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
      .swap_req_in(swap_req_in), .swap_ack_out(swap_ack_out),
      .fb_sel_out(fb_sel_out), .frame_start_out(frame_start_out),
      .rd_addr_out(rd_addr_out), .rd_en_out(rd_en_out), .rd_data_in(rd_data_in),
      .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
      .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out)
   );

   always #5 pixel_clk_in = ~pixel_clk_in;

   // Framebuffer content as a fixed function of the 17-bit address; address 0 holds 12'hF84.
   function automatic logic [11:0] pixel_fn(input logic [16:0] a);
      logic [31:0] t;
      t = {15'd0, a} * 32'd13;
      return t[11:0] ^ {7'd0, a[16:12]} ^ 12'hF84;
   endfunction

   // BRAM model: data appears two cycles after rd_addr_out.
   logic [16:0] a1 = 17'd0, a2 = 17'd0;
   always @(posedge pixel_clk_in) begin
      a1 <= rd_addr_out;
      a2 <= a1;
   end
   assign rd_data_in = pixel_fn(a2);

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int   hist_h [MAXC];
   int   hist_v [MAXC];
   bit   hist_hs[MAXC], hist_vs[MAXC], hist_bl[MAXC], hist_req[MAXC], hist_rst[MAXC];
   bit   moved_m[MAXC], sel_m[MAXC];
   logic [16:0] addr_m[MAXC];

   bit          exp_sel, exp_ack, exp_fs, exp_en, exp_hs, exp_vs, exp_bl;
   logic [16:0] exp_addr;
   logic [11:0] exp_rgb;

   function automatic bit rst_at(input int k);
      if (k < 0) return 1'b1;
      return hist_rst[k];
   endfunction

   function automatic bit act_at(input int k);
      return (hist_h[k] < H_ACTIVE) && (hist_v[k] < V_ACTIVE);
   endfunction

   function automatic logic [15:0] fba(input int k);
      int a;
      a = (hist_v[k] / 4) * FB_W + hist_h[k] / 4;
      return a[15:0];
   endfunction

   function automatic bit evt_e(input int k);
      return moved_m[k] && (hist_h[k] == 0) && (hist_v[k] == V_ACTIVE);
   endfunction

   // Drive one cycle of inputs, advance the clock, and compute what the outputs should now show.
   task automatic step(input int h, input int v, input bit hs, input bit vs,
                       input bit bl, input bit req, input bit r);
      int n;
      int k;
      bit win;
      if (cyc >= MAXC - 2) begin
         $display("FAIL cycle_budget: cyc=%0d limit=%0d", cyc, MAXC - 2);
         $fatal(1, "cycle budget exhausted");
      end
      n = cyc;
      hcount_in = h[10:0]; vcount_in = v[9:0];
      hsync_in = hs; vsync_in = vs; blank_in = bl; swap_req_in = req; rst = r;
      hist_h[n] = h; hist_v[n] = v; hist_hs[n] = hs; hist_vs[n] = vs;
      hist_bl[n] = bl; hist_req[n] = req; hist_rst[n] = r;
      if (n == 0) moved_m[n] = 1'b1;
      else moved_m[n] = rst_at(n - 1) || (h != hist_h[n-1]) || (v != hist_v[n-1]);
      @(posedge pixel_clk_in);
      #1;
      cyc = n + 1;
      sel_m[n+1] = r ? 1'b0 : ((evt_e(n) && req) ? !sel_m[n] : sel_m[n]);
      exp_sel = sel_m[n+1];
      exp_ack = !r && evt_e(n) && req;
      exp_fs  = !r && moved_m[n] && (h == 0) && (v == 0);
      exp_en  = !r && act_at(n);
      addr_m[n+1] = r ? 17'd0 : (act_at(n) ? {sel_m[n], fba(n)} : addr_m[n]);
      exp_addr = addr_m[n+1];
      win = rst_at(n) || rst_at(n - 1) || rst_at(n - 2) || rst_at(n - 3);
      if (win) begin
         exp_hs = 1'b0; exp_vs = 1'b0; exp_bl = 1'b1; exp_rgb = 12'd0;
      end else begin
         k = n - 3;
         exp_hs = hist_hs[k]; exp_vs = hist_vs[k]; exp_bl = hist_bl[k];
         exp_rgb = (act_at(k) && !hist_bl[k]) ? pixel_fn({sel_m[k], fba(k)}) : 12'd0;
      end
   endtask

   // One cycle from a well-behaved timing generator: syncs idle high, blank outside the active area.
   task automatic px(input int h, input int v, input bit req);
      step(h, v, 1'b1, 1'b1, !((h < H_ACTIVE) && (v < V_ACTIVE)), req, 1'b0);
   endtask

   task automatic test_reset;
      for (int i = 0; i < 6; i++) begin
         step($urandom_range(0, H_TOTAL - 1), $urandom_range(0, V_TOTAL - 1),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
         checks++;
         if ({fb_sel_out, swap_ack_out, frame_start_out, rd_en_out} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got sel/ack/fs/en=%b want 0000", {fb_sel_out, swap_ack_out, frame_start_out, rd_en_out});
         end
         checks++;
         if (rd_addr_out !== 17'd0) begin
            errors++; $display("FAIL reset_addr: got %0d want 0", rd_addr_out);
         end
         checks++;
         if ({red_out, green_out, blue_out, hsync_out, vsync_out, blank_out} !== 15'b000000000000001) begin
            errors++;
            $display("FAIL reset_video: got rgb=%h hs=%b vs=%b bl=%b want rgb=000 hs=0 vs=0 bl=1",
                     {red_out, green_out, blue_out}, hsync_out, vsync_out, blank_out);
         end
      end
   endtask

   task automatic test_first_pixel;
      for (int i = 0; i < 8; i++) begin
         px(i, 0, 1'b0);
         checks++;
         if (frame_start_out !== (i == 0)) begin
            errors++; $display("FAIL first_fs: step %0d got %b want %b", i, frame_start_out, (i == 0));
         end
         if (i == 3) begin
            checks++;
            if ({red_out, green_out, blue_out, blank_out} !== {4'hF, 4'h8, 4'h4, 1'b0}) begin
               errors++;
               $display("FAIL first_rgb: got r=%h g=%h b=%h bl=%b want r=f g=8 b=4 bl=0",
                        red_out, green_out, blue_out, blank_out);
            end
         end
         checks++;
         if ({red_out, green_out, blue_out} !== exp_rgb) begin
            errors++; $display("FAIL first_rgb_model: step %0d got %h want %h", i, {red_out, green_out, blue_out}, exp_rgb);
         end
      end
   endtask

   task automatic test_address;
      for (int h = 4; h < 8; h++) begin
         px(h, 5, 1'b0);
         checks++;
         if (rd_addr_out !== 17'd257 || rd_en_out !== 1'b1) begin
            errors++; $display("FAIL addr_257: h=%0d got addr=%0d en=%b want 257 en=1", h, rd_addr_out, rd_en_out);
         end
      end
      for (int h = 1020; h < 1024; h++) begin
         px(h, 767, 1'b0);
         checks++;
         if (rd_addr_out !== 17'd49151) begin
            errors++; $display("FAIL addr_last: h=%0d got %0d want 49151", h, rd_addr_out);
         end
      end
      px(1100, 767, 1'b0);
      checks++;
      if (rd_addr_out !== 17'd49151 || rd_en_out !== 1'b0) begin
         errors++; $display("FAIL addr_hold: got addr=%0d en=%b want 49151 en=0", rd_addr_out, rd_en_out);
      end
      checks++;
      if (rd_addr_out !== exp_addr) begin
         errors++; $display("FAIL addr_model: got %0d want %0d", rd_addr_out, exp_addr);
      end
   endtask

   task automatic test_hsync;
      int low_cnt = 0;
      int first_low = -1;
      int blank_leak = 0;
      int j = 0;
      for (int h = 1000; h < H_TOTAL + 10; h++) begin
         if (h < H_TOTAL)
            step(h, 10, !(h >= 1048 && h < 1184), 1'b1, h >= H_ACTIVE, 1'b0, 1'b0);
         else
            px(h - H_TOTAL, 11, 1'b0);
         if (hsync_out == 1'b0) begin
            low_cnt++;
            if (first_low < 0) first_low = j;
         end
         if (blank_out == 1'b1 && {red_out, green_out, blue_out} != 12'd0) blank_leak++;
         checks++;
         if (hsync_out !== exp_hs) begin
            errors++; $display("FAIL hsync_model: step %0d got %b want %b", j, hsync_out, exp_hs);
         end
         j++;
      end
      checks++;
      if (low_cnt != 136) begin
         errors++; $display("FAIL hsync_width: got %0d want 136", low_cnt);
      end
      checks++;
      if (first_low != 48 + 3) begin
         errors++; $display("FAIL hsync_delay: first low after step %0d want %0d", first_low, 51);
      end
      checks++;
      if (blank_leak != 0) begin
         errors++; $display("FAIL blank_rgb: got %0d nonzero blank pixels want 0", blank_leak);
      end
   endtask

   task automatic test_swap;
      bit s0;
      s0 = sel_m[cyc];
      for (int h = 0; h < 4; h++) begin
         px(h, 100, 1'b1);
         checks++;
         if (swap_ack_out !== 1'b0 || fb_sel_out !== s0) begin
            errors++; $display("FAIL swap_midframe: got ack=%b sel=%b want ack=0 sel=%b", swap_ack_out, fb_sel_out, s0);
         end
      end
      for (int h = 1020; h < 1024; h++) begin
         px(h, 767, 1'b1);
         checks++;
         if (swap_ack_out !== 1'b0 || fb_sel_out !== s0) begin
            errors++; $display("FAIL swap_early: got ack=%b sel=%b want ack=0 sel=%b", swap_ack_out, fb_sel_out, s0);
         end
      end
      px(0, 768, 1'b1);
      checks++;
      if (swap_ack_out !== 1'b1 || fb_sel_out !== !s0) begin
         errors++; $display("FAIL swap_take: got ack=%b sel=%b want ack=1 sel=%b", swap_ack_out, fb_sel_out, !s0);
      end
      px(1, 768, 1'b1);
      checks++;
      if (swap_ack_out !== 1'b0 || fb_sel_out !== !s0) begin
         errors++; $display("FAIL swap_pulse: got ack=%b sel=%b want ack=0 sel=%b", swap_ack_out, fb_sel_out, !s0);
      end
      for (int h = 2; h < 6; h++) px(h, 768, 1'b0);
      for (int h = 0; h < 4; h++) begin
         px(h, 0, 1'b0);
         checks++;
         if (rd_addr_out[16] !== !s0 || rd_addr_out !== exp_addr) begin
            errors++; $display("FAIL swap_addr_msb: got %h want msb=%b addr=%h", rd_addr_out, !s0, exp_addr);
         end
      end
   endtask

   task automatic test_pause;
      int acks = 0;
      int fs_cnt = 0;
      bit s0;
      px(1023, 767, 1'b1);
      s0 = sel_m[cyc];
      for (int i = 0; i < 10; i++) begin
         px(0, 768, 1'b1);
         if (swap_ack_out) acks++;
      end
      checks++;
      if (acks != 1) begin
         errors++; $display("FAIL pause_acks: got %0d want 1", acks);
      end
      checks++;
      if (fb_sel_out !== !s0) begin
         errors++; $display("FAIL pause_sel: got %b want %b", fb_sel_out, !s0);
      end
      px(5, 768, 1'b0);
      for (int i = 0; i < 10; i++) begin
         px(0, 0, 1'b0);
         if (frame_start_out) fs_cnt++;
      end
      checks++;
      if (fs_cnt != 1) begin
         errors++; $display("FAIL pause_fs: got %0d pulses want 1", fs_cnt);
      end
   endtask

   task automatic test_mid_reset;
      if (sel_m[cyc] == 1'b0) begin
         px(1023, 767, 1'b1);
         px(0, 768, 1'b1);
         px(1, 768, 1'b0);
      end
      checks++;
      if (fb_sel_out !== 1'b1) begin
         errors++; $display("FAIL midrst_pre_sel: got %b want 1", fb_sel_out);
      end
      for (int h = 100; h < 110; h++) px(h, 300, 1'b0);
      step(110, 300, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      checks++;
      if ({fb_sel_out, blank_out, swap_ack_out} !== 3'b010 || {red_out, green_out, blue_out} !== 12'd0) begin
         errors++;
         $display("FAIL midrst_state: got sel=%b bl=%b ack=%b rgb=%h want sel=0 bl=1 ack=0 rgb=000",
                  fb_sel_out, blank_out, swap_ack_out, {red_out, green_out, blue_out});
      end
      for (int h = 111; h < 120; h++) begin
         px(h, 300, 1'b1);
         checks++;
         if (swap_ack_out !== 1'b0 || fb_sel_out !== 1'b0) begin
            errors++; $display("FAIL midrst_noack: got ack=%b sel=%b want 0 0", swap_ack_out, fb_sel_out);
         end
         checks++;
         if ({red_out, green_out, blue_out} !== exp_rgb || rd_addr_out[16] !== 1'b0) begin
            errors++; $display("FAIL midrst_resume: got rgb=%h addr=%h want rgb=%h msb=0",
                               {red_out, green_out, blue_out}, rd_addr_out, exp_rgb);
         end
      end
   endtask

   task automatic test_random;
      int h = 0;
      int v = 0;
      int mode;
      for (int i = 0; i < 3000; i++) begin
         mode = $urandom_range(0, 9);
         if (mode <= 3) begin
            h = h + 1;
            if (h >= H_TOTAL) begin h = 0; v = (v + 1) % V_TOTAL; end
         end else if (mode == 6) begin
            case ($urandom_range(0, 2))
               0: begin h = 0; v = V_ACTIVE; end
               1: begin h = 0; v = 0; end
               default: begin h = 1023; v = 767; end
            endcase
         end else if (mode >= 7) begin
            h = $urandom_range(0, H_TOTAL - 1);
            v = $urandom_range(0, V_TOTAL - 1);
         end
         step(h, v, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 2) != 0), ($urandom_range(0, 149) == 0));
         checks++;
         if ({fb_sel_out, swap_ack_out, frame_start_out, rd_en_out} !== {exp_sel, exp_ack, exp_fs, exp_en}) begin
            errors++;
            $display("FAIL rand_ctrl: cyc %0d got sel/ack/fs/en=%b want %b", cyc,
                     {fb_sel_out, swap_ack_out, frame_start_out, rd_en_out}, {exp_sel, exp_ack, exp_fs, exp_en});
         end
         checks++;
         if (rd_addr_out !== exp_addr) begin
            errors++; $display("FAIL rand_addr: cyc %0d got %h want %h", cyc, rd_addr_out, exp_addr);
         end
         checks++;
         if ({red_out, green_out, blue_out, hsync_out, vsync_out, blank_out} !== {exp_rgb, exp_hs, exp_vs, exp_bl}) begin
            errors++;
            $display("FAIL rand_video: cyc %0d got rgb=%h hs/vs/bl=%b want rgb=%h hs/vs/bl=%b", cyc,
                     {red_out, green_out, blue_out}, {hsync_out, vsync_out, blank_out}, exp_rgb, {exp_hs, exp_vs, exp_bl});
         end
      end
   endtask

   initial begin
      sel_m[0]  = 1'b0;
      addr_m[0] = 17'd0;
      test_reset();
      test_first_pixel();
      test_address();
      test_hsync();
      test_swap();
      test_pause();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
